// File: rtl/bmlp_layer_sched.sv
// Binary-MLP fully-connected layer scheduler: issues weight/activation reads, accumulator
// controls and per-neuron output writes. Optional busy-cycle counter under BMLP_SCHED_PERF_EN.
module bmlp_layer_sched #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_neurons,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [ADDR_W-1:0] w_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [CNT_W-1:0]  x_addr,
    output logic              acc_en,
    output logic              acc_first,
    output logic              out_we,
    output logic [CNT_W-1:0]  out_addr,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_cycles
);

    localparam logic [CNT_W-1:0]  CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StFin} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   nn_q, nn_d, nw_q, nw_d;
    logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [CNT_W-1:0]   x_addr_q, x_addr_d, out_addr_q, out_addr_d;
    logic               rd_en_q, rd_en_d, acc_en_q, acc_en_d, acc_first_q, acc_first_d;
    logic               out_we_q, out_we_d, busy_q, busy_d, done_q, done_d;

    // w_addr_q doubles as the running weight pointer, x_addr_q as the word index and
    // out_addr_q as the neuron index.
    always_comb begin
        state_d     = state_q;
        nn_d        = nn_q;
        nw_d        = nw_q;
        w_addr_d    = w_addr_q;
        x_addr_d    = x_addr_q;
        out_addr_d  = out_addr_q;
        rd_en_d     = 1'b0;
        out_we_d    = 1'b0;
        done_d      = 1'b0;
        acc_en_d    = rd_en_q;
        acc_first_d = rd_en_q && (x_addr_q == '0);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    nn_d       = num_neurons;
                    nw_d       = num_words;
                    out_addr_d = '0;
                    x_addr_d   = '0;
                    if ((num_neurons == '0) || (num_words == '0)) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StRead;
                        rd_en_d  = 1'b1;
                        w_addr_d = w_base;
                    end
                end
            end
            StRead: begin
                // Compare against nw-1 so an all-ones word count never overflows.
                if (x_addr_q == nw_q - CntOne) begin
                    state_d = StDrain;
                end else begin
                    rd_en_d  = 1'b1;
                    x_addr_d = x_addr_q + CntOne;
                    w_addr_d = w_addr_q + AddrOne;
                end
            end
            StDrain: begin
                state_d  = StWrite;
                out_we_d = 1'b1;
            end
            StWrite: begin
                if (out_ready) begin
                    if (out_addr_q == nn_q - CntOne) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = StRead;
                        out_addr_d = out_addr_q + CntOne;
                        rd_en_d    = 1'b1;
                        x_addr_d   = '0;
                        w_addr_d   = w_addr_q + AddrOne;
                    end
                end else begin
                    out_we_d = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            nn_q        <= '0;
            nw_q        <= '0;
            w_addr_q    <= '0;
            x_addr_q    <= '0;
            out_addr_q  <= '0;
            rd_en_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_first_q <= 1'b0;
            out_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nn_q        <= nn_d;
            nw_q        <= nw_d;
            w_addr_q    <= w_addr_d;
            x_addr_q    <= x_addr_d;
            out_addr_q  <= out_addr_d;
            rd_en_q     <= rd_en_d;
            acc_en_q    <= acc_en_d;
            acc_first_q <= acc_first_d;
            out_we_q    <= out_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign w_addr    = w_addr_q;
    assign x_addr    = x_addr_q;
    assign acc_en    = acc_en_q;
    assign acc_first = acc_first_q;
    assign out_we    = out_we_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef BMLP_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == StIdle) && start) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
